acc_cpu_core: RTL and testbench

- Parametrised accumulator CPU core; successor to the fixed 8-bit CPU top.
- Data width and memory depth are generic. Adds carry and zero flags, conditional jumps, a store instruction and a host program-load port.
- Unified internal program/data memory; multicycle FETCH/DECODE/EXEC sequencer.
- Sits under the chip top: pins map to the run, load and output ports.

---
 rtl/acc_cpu_core.sv | 156 +++++++++++++++
 tb/tb_acc_cpu_core.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu_core.sv
// Parametrised accumulator CPU core: unified program/data memory, carry/zero flags,
// a multicycle FETCH/DECODE/EXEC sequencer and a host program-load port used while run=0.
module acc_cpu_core #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              halted,
   output logic [ADDR_W-1:0] pc_dbg,
   output logic [1:0]        flags_dbg
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   localparam logic [3:0] OpLda = 4'h1;
   localparam logic [3:0] OpAdd = 4'h2;
   localparam logic [3:0] OpSub = 4'h3;
   localparam logic [3:0] OpSta = 4'h4;
   localparam logic [3:0] OpLdi = 4'h5;
   localparam logic [3:0] OpJmp = 4'h6;
   localparam logic [3:0] OpJc  = 4'h7;
   localparam logic [3:0] OpJz  = 4'h8;
   localparam logic [3:0] OpOut = 4'h9;
   localparam logic [3:0] OpHlt = 4'hF;

   typedef enum logic [1:0] {StFetch, StDecode, StExec, StHalt} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d, mar_q, mar_d;
   // Only opcode and operand fields are kept; the bits between them are ignored.
   logic [ADDR_W+3:0]   ir_q, ir_d;
   logic [DATA_W-1:0]   acc_q, acc_d, out_q, out_d;
   logic                c_q, c_d, z_q, z_d, valid_q, valid_d;
   logic                core_we, host_we;
   logic [DATA_W-1:0]   mem [Depth];
   logic [DATA_W-1:0]   mem_rd;
   logic [DATA_W:0]     add_res, sub_res;
   logic [3:0]          opcode;

   assign opcode  = ir_q[ADDR_W+3 -: 4];
   assign mem_rd  = mem[mar_q];
   assign add_res = {1'b0, acc_q} + {1'b0, mem_rd};
   // MSB of the widened difference is the borrow.
   assign sub_res = {1'b0, acc_q} - {1'b0, mem_rd};
   assign host_we = prog_we & ~run;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      mar_d   = mar_q;
      acc_d   = acc_q;
      c_d     = c_q;
      z_d     = z_q;
      out_d   = out_q;
      valid_d = 1'b0;
      core_we = 1'b0;
      if (run) begin
         unique case (state_q)
            StFetch: begin
               ir_d    = {mem[pc_q][DATA_W-1 -: 4], mem[pc_q][ADDR_W-1:0]};
               pc_d    = pc_q + ADDR_W'(1);
               state_d = StDecode;
            end
            StDecode: begin
               mar_d   = ir_q[ADDR_W-1:0];
               state_d = StExec;
            end
            StExec: begin
               state_d = StFetch;
               case (opcode)
                  OpLda: begin
                     acc_d = mem_rd;
                     z_d   = (mem_rd == '0);
                  end
                  OpAdd: begin
                     acc_d = add_res[DATA_W-1:0];
                     c_d   = add_res[DATA_W];
                     z_d   = (add_res[DATA_W-1:0] == '0);
                  end
                  OpSub: begin
                     acc_d = sub_res[DATA_W-1:0];
                     c_d   = ~sub_res[DATA_W];
                     z_d   = (sub_res[DATA_W-1:0] == '0);
                  end
                  OpSta: core_we = 1'b1;
                  OpLdi: begin
                     acc_d = {{(DATA_W-ADDR_W){1'b0}}, mar_q};
                     z_d   = (mar_q == '0);
                  end
                  OpJmp: pc_d = mar_q;
                  OpJc:  if (c_q) pc_d = mar_q;
                  OpJz:  if (z_q) pc_d = mar_q;
                  OpOut: begin
                     out_d   = acc_q;
                     valid_d = 1'b1;
                  end
                  OpHlt: state_d = StHalt;
                  default: ;
               endcase
            end
            StHalt: ;
            default: state_d = StFetch;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
         pc_q    <= '0;
         ir_q    <= '0;
         mar_q   <= '0;
         acc_q   <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         mar_q   <= mar_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         z_q     <= z_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   // Memory is deliberately not cleared by reset; reset only blocks writes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (core_we) begin
            mem[mar_q] <= acc_q;
         end else if (host_we) begin
            mem[prog_addr] <= prog_data;
         end
      end
   end

   assign out_data  = out_q;
   assign out_valid = valid_q;
   assign halted    = (state_q == StHalt);
   assign pc_dbg    = pc_q;
   assign flags_dbg = {c_q, z_q};

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: loads small programs through the host port and checks
// outputs, flags, PC and halt behaviour at fixed run-edge counts.
module tb_acc_cpu_core;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          run;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [DW-1:0] prog_data;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          halted;
   logic [AW-1:0] pc_dbg;
   logic [1:0]    flags_dbg;

   int total = 0;
   int bad   = 0;
   logic [7:0] img [16];

   always #5 clk = ~clk;

   acc_cpu_core #(
      .DATA_W (DW),
      .ADDR_W (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .halted    (halted),
      .pc_dbg    (pc_dbg),
      .flags_dbg (flags_dbg)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   task automatic write_word(input int a, input logic [7:0] d);
      run       = 1'b0;
      prog_we   = 1'b1;
      prog_addr = AW'(a);
      prog_data = d;
      step(1);
      prog_we   = 1'b0;
   endtask

   task automatic clear_img();
      for (int i = 0; i < 16; i++) img[i] = 8'h00;
   endtask

   task automatic load_img();
      for (int i = 0; i < 16; i++) write_word(i, img[i]);
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      #1;
      do_reset();
      chk("rst_pc", 16'(pc_dbg), 16'h0);
      chk("rst_flags", 16'(flags_dbg), 16'h0);
      chk("rst_halted", 16'(halted), 16'h0);
      chk("rst_valid", 16'(out_valid), 16'h0);
      chk("rst_out", 16'(out_data), 16'h00);

      // Basic program: LDA 14; ADD 15; OUT; HLT with 5 + 3.
      clear_img();
      img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h90; img[3] = 8'hF0;
      img[14] = 8'h05; img[15] = 8'h03;
      load_img();
      run = 1'b1;
      step(8);
      chk("t1_valid_pre", 16'(out_valid), 16'h0);
      step(1);
      chk("t1_valid", 16'(out_valid), 16'h1);
      chk("t1_out", 16'(out_data), 16'h08);
      step(1);
      chk("t1_valid_post", 16'(out_valid), 16'h0);
      chk("t1_out_held", 16'(out_data), 16'h08);
      step(1);
      chk("t1_halted_pre", 16'(halted), 16'h0);
      step(1);
      chk("t1_halted", 16'(halted), 16'h1);
      chk("t1_flags", 16'(flags_dbg), 16'h0);
      step(3);
      chk("t1_halt_pc", 16'(pc_dbg), 16'h4);
      chk("t1_halt_sticky", 16'(halted), 16'h1);

      // SUB: 3-5 borrows, 5-5 is zero with no borrow.
      run = 1'b0;
      do_reset();
      clear_img();
      img[0] = 8'h53; img[1] = 8'h3E; img[2] = 8'h90;
      img[3] = 8'h55; img[4] = 8'h3E; img[5] = 8'h90; img[6] = 8'hF0;
      img[14] = 8'h05;
      load_img();
      run = 1'b1;
      step(9);
      chk("t2_out_borrow", 16'(out_data), 16'hFE);
      chk("t2_valid_borrow", 16'(out_valid), 16'h1);
      chk("t2_flags_borrow", 16'(flags_dbg), 16'h0);
      step(9);
      chk("t2_out_zero", 16'(out_data), 16'h00);
      chk("t2_valid_zero", 16'(out_valid), 16'h1);
      chk("t2_flags_zero", 16'(flags_dbg), 16'h3);

      // ADD overflow then JC/JZ both taken; LDI leaves C alone.
      run = 1'b0;
      do_reset();
      clear_img();
      img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h74; img[3] = 8'hF0;
      img[4] = 8'h86; img[5] = 8'hF0; img[6] = 8'h52; img[7] = 8'h90; img[8] = 8'hF0;
      img[14] = 8'hFF; img[15] = 8'h01;
      load_img();
      run = 1'b1;
      step(6);
      chk("t3_flags_ovf", 16'(flags_dbg), 16'h3);
      step(3);
      chk("t3_jc_pc", 16'(pc_dbg), 16'h4);
      step(3);
      chk("t3_jz_pc", 16'(pc_dbg), 16'h6);
      step(3);
      chk("t3_ldi_keeps_c", 16'(flags_dbg[1]), 16'h1);
      step(3);
      chk("t3_out", 16'(out_data), 16'h02);
      chk("t3_valid", 16'(out_valid), 16'h1);
      step(3);
      chk("t3_halted", 16'(halted), 16'h1);

      // PC wrap and self-modifying code: word 0 becomes HLT (0xB0+0x40) via STA 0.
      run = 1'b0;
      do_reset();
      clear_img();
      img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h40;
      img[14] = 8'hB0; img[15] = 8'h40;
      load_img();
      run = 1'b1;
      step(45);
      chk("t4_pc15", 16'(pc_dbg), 16'hF);
      step(1);
      chk("t4_pc_wrap", 16'(pc_dbg), 16'h0);
      step(2);
      chk("t4_not_halted", 16'(halted), 16'h0);
      step(1);
      chk("t4_pc1", 16'(pc_dbg), 16'h1);
      step(2);
      chk("t4_halted", 16'(halted), 16'h1);

      // Run gating mid-DECODE and prog_we ignored while running.
      run = 1'b0;
      do_reset();
      clear_img();
      img[0] = 8'h1E; img[1] = 8'h2F; img[2] = 8'h90; img[3] = 8'hF0;
      img[14] = 8'h05; img[15] = 8'h03;
      load_img();
      run = 1'b1;
      step(1);
      run = 1'b0;
      step(5);
      chk("t5_frozen_pc", 16'(pc_dbg), 16'h1);
      chk("t5_frozen_valid", 16'(out_valid), 16'h0);
      run = 1'b1;
      step(1);
      prog_we = 1'b1; prog_addr = 4'h2; prog_data = 8'hF0;
      step(1);
      prog_we = 1'b0;
      step(5);
      chk("t5_valid_pre", 16'(out_valid), 16'h0);
      step(1);
      chk("t5_valid", 16'(out_valid), 16'h1);
      chk("t5_out", 16'(out_data), 16'h08);
      chk("t5_not_halted", 16'(halted), 16'h0);

      // Reset during EXEC of STA 14 with acc=0x42 must discard the store.
      run = 1'b0;
      do_reset();
      clear_img();
      img[0] = 8'h1D; img[1] = 8'h4E; img[2] = 8'h1E; img[3] = 8'h90; img[4] = 8'hF0;
      img[13] = 8'h42; img[14] = 8'h07;
      load_img();
      run = 1'b1;
      step(5);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      run = 1'b0;
      chk("t6_pc", 16'(pc_dbg), 16'h0);
      chk("t6_flags", 16'(flags_dbg), 16'h0);
      chk("t6_halted", 16'(halted), 16'h0);
      chk("t6_valid", 16'(out_valid), 16'h0);
      write_word(0, 8'h90);
      write_word(1, 8'h1E);
      write_word(2, 8'h90);
      write_word(3, 8'hF0);
      run = 1'b1;
      step(3);
      chk("t6_acc_zero_valid", 16'(out_valid), 16'h1);
      chk("t6_acc_zero", 16'(out_data), 16'h00);
      step(6);
      chk("t6_mem14_valid", 16'(out_valid), 16'h1);
      chk("t6_mem14_kept", 16'(out_data), 16'h07);
      chk("t6_flags_after", 16'(flags_dbg), 16'h0);
      run = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
